wb_arbiter: RTL and testbench

Writeback arbiter that owns the single write port of the integer register file. It merges two result streams: the single-cycle ALU result (fixed priority, no backpressure) and a buffered long-latency stream (loads, mul/div) with valid/ready handshake. It drives a registered `we`/`wa`/`wd` triple directly into the register file write port. It also reports per-operand pending status so issue logic can stall on outstanding long-latency destinations.

---
 rtl/wb_arbiter.sv | 167 ++++++++++++++++
 tb/tb_wb_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter for the single register-file write port: ALU results win, long-latency results wait in a small queue.
// Latency: ALU result is on we/wa/wd one cycle after capture; a queued result reaches the port one cycle after it is accepted, at the earliest.
// Backpressure: the ALU path is never stalled; the long-latency path uses b_valid/b_ready and stalls while the queue is full.
module wb_arbiter #(
  parameter int LQ_DEPTH   = 4,
  parameter int LQ_AW      = 2,
  parameter int RD_WIDTH   = 5,
  parameter int DATA_WIDTH = 32,
  parameter int RS1_WIDTH  = 5,
  parameter int RS2_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_valid,
  input  logic [RD_WIDTH-1:0]   a_rd,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [RD_WIDTH-1:0]   b_rd,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  we,
  output logic [RD_WIDTH-1:0]   wa,
  output logic [DATA_WIDTH-1:0] wd,
  input  logic [RS1_WIDTH-1:0]  rs1,
  input  logic [RS2_WIDTH-1:0]  rs2,
  output logic                  rs1_pend,
  output logic                  rs2_pend,
  output logic [LQ_AW:0]        lq_count
);

  // Widest of the register-index widths, so operand and destination indices compare without truncation.
  localparam int CMP_W = (RD_WIDTH > RS1_WIDTH)
                         ? ((RD_WIDTH > RS2_WIDTH) ? RD_WIDTH : RS2_WIDTH)
                         : ((RS1_WIDTH > RS2_WIDTH) ? RS1_WIDTH : RS2_WIDTH);

  localparam logic [LQ_AW:0] FULL_CNT = (LQ_AW+1)'(LQ_DEPTH);

  // One queue slot. A cleared live bit marks an entry overwritten by a younger ALU result:
  // it still occupies its slot and is popped in order, but it is never written.
  typedef struct packed {
    logic                  live;
    logic [RD_WIDTH-1:0]   rd;
    logic [DATA_WIDTH-1:0] data;
  } lq_entry_t;

  lq_entry_t             lq_q [LQ_DEPTH];
  lq_entry_t             lq_d [LQ_DEPTH];
  logic [LQ_AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [LQ_AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LQ_AW:0]        count_q, count_d;

  logic                  we_q, we_d;
  logic [RD_WIDTH-1:0]   wa_q, wa_d;
  logic [DATA_WIDTH-1:0] wd_q, wd_d;

  logic                  a_wr;
  logic                  push;
  logic                  pop;
  lq_entry_t             head;

  // b_ready comes from the registered count, so a pop in the same cycle never opens room for a push.
  assign b_ready  = rst_n && (count_q != FULL_CNT);

  // x0 destinations are never written: ALU ones are dropped, queued ones are acknowledged but not stored.
  assign a_wr     = a_valid && (a_rd != '0);
  assign push     = b_valid && b_ready && (b_rd != '0);
  assign pop      = !a_wr && (count_q != '0);
  assign head     = lq_q[rd_ptr_q];

  assign we       = we_q;
  assign wa       = wa_q;
  assign wd       = wd_q;
  assign lq_count = count_q;

  // Queue next state: squash older same-destination entries on an ALU write, retire the head, append the new entry.
  always_comb begin
    for (int i = 0; i < LQ_DEPTH; i++) begin
      lq_d[i] = lq_q[i];
      if (a_wr && lq_q[i].live && (lq_q[i].rd == a_rd)) begin
        lq_d[i].live = 1'b0;
      end
    end
    // A retired slot must stop reporting as pending.
    if (pop) begin
      lq_d[rd_ptr_q].live = 1'b0;
    end
    // The push slot never equals the pop slot (that would need an empty or full queue),
    // and a pushed entry is younger than a same-cycle ALU result, so it is stored live.
    if (push) begin
      lq_d[wr_ptr_q] = '{live: 1'b1, rd: b_rd, data: b_data};
    end
  end

  // Pointer and occupancy next state; a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Write-port selection: ALU first, then a live queue head; otherwise drop we and hold address/data.
  always_comb begin
    we_d = 1'b0;
    wa_d = wa_q;
    wd_d = wd_q;
    if (a_wr) begin
      we_d = 1'b1;
      wa_d = a_rd;
      wd_d = a_data;
    end else if (pop && head.live) begin
      we_d = 1'b1;
      wa_d = head.rd;
      wd_d = head.data;
    end
  end

  // Operand hazard flags look only at registered queue state, never at the incoming b_* request.
  always_comb begin
    rs1_pend = 1'b0;
    rs2_pend = 1'b0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      if (lq_q[i].live && (CMP_W'(lq_q[i].rd) == CMP_W'(rs1)) && (rs1 != '0)) begin
        rs1_pend = 1'b1;
      end
      if (lq_q[i].live && (CMP_W'(lq_q[i].rd) == CMP_W'(rs2)) && (rs2 != '0)) begin
        rs2_pend = 1'b1;
      end
    end
  end

  // State registers; reset discards every queued entry without writing it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LQ_DEPTH; i++) begin
        lq_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      we_q     <= 1'b0;
      wa_q     <= '0;
      wd_q     <= '0;
    end else begin
      for (int i = 0; i < LQ_DEPTH; i++) begin
        lq_q[i] <= lq_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      we_q     <= we_d;
      wa_q     <= wa_d;
      wd_q     <= wd_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: table of per-cycle vectors plus a hand-written starvation/drain sequence.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
// Expected values are hand-derived from the arbiter's behaviour, not read back from the design.
module tb_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        a_valid;
  logic [4:0]  a_rd;
  logic [31:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_rd;
  logic [31:0] b_data;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        rs1_pend;
  logic        rs2_pend;
  logic [2:0]  lq_count;

  int checks;
  int errors;

  wb_arbiter #(
    .LQ_DEPTH(4), .LQ_AW(2), .RD_WIDTH(5), .DATA_WIDTH(32), .RS1_WIDTH(5), .RS2_WIDTH(5)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .we(we), .wa(wa), .wd(wd),
    .rs1(rs1), .rs2(rs2), .rs1_pend(rs1_pend), .rs2_pend(rs2_pend),
    .lq_count(lq_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rst_n;
    logic        a_valid;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    logic        b_valid;
    logic [4:0]  b_rd;
    logic [31:0] b_data;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        exp_we;
    logic [4:0]  exp_wa;
    logic [31:0] exp_wd;
    logic        exp_b_ready;
    logic [2:0]  exp_cnt;
    logic        exp_p1;
    logic        exp_p2;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    logic r, logic av, logic [4:0] ard, logic [31:0] ad,
    logic bv, logic [4:0] brd, logic [31:0] bd,
    logic [4:0] s1, logic [4:0] s2,
    logic ewe, logic [4:0] ewa, logic [31:0] ewd, logic ebr, logic [2:0] ecnt,
    logic ep1, logic ep2);
    vec_t v;
    v.rst_n = r;   v.a_valid = av; v.a_rd = ard; v.a_data = ad;
    v.b_valid = bv; v.b_rd = brd; v.b_data = bd;
    v.rs1 = s1;    v.rs2 = s2;
    v.exp_we = ewe; v.exp_wa = ewa; v.exp_wd = ewd; v.exp_b_ready = ebr;
    v.exp_cnt = ecnt; v.exp_p1 = ep1; v.exp_p2 = ep2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic bv, input logic [4:0] brd, input logic [31:0] bd,
                       input logic [4:0] s1, input logic [4:0] s2);
    rst_n = r; a_valid = av; a_rd = ard; a_data = ad;
    b_valid = bv; b_rd = brd; b_data = bd; rs1 = s1; rs2 = s2;
  endtask

  int nw;

  initial begin
    checks = 0;
    errors = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    //             rst av ard adat      bv brd bdat      rs1 rs2  we wa wd       br cnt p1 p2
    vecs.push_back(mk(0, 1, 5, 32'h55,   1, 6, 32'h66,   0, 0,    0, 0, 32'h0,    0, 0, 0, 0)); // reset, inputs active
    vecs.push_back(mk(0, 1, 5, 32'h55,   1, 6, 32'h66,   0, 0,    0, 0, 32'h0,    0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 5, 32'h1234, 0, 0, 32'h0,    0, 0,    1, 5, 32'h1234, 1, 0, 0, 0)); // ALU write
    vecs.push_back(mk(1, 0, 0, 32'h0,    0, 0, 32'h0,    0, 0,    0, 5, 32'h1234, 1, 0, 0, 0)); // idle holds wa/wd
    vecs.push_back(mk(1, 1, 0, 32'hDEAD, 0, 0, 32'h0,    0, 0,    0, 5, 32'h1234, 1, 0, 0, 0)); // ALU x0 dropped
    vecs.push_back(mk(1, 1, 9, 32'h90,   1, 1, 32'hA1,   3, 1,    1, 9, 32'h90,   1, 1, 0, 1)); // fill under A priority
    vecs.push_back(mk(1, 1, 9, 32'h91,   1, 2, 32'hA2,   3, 1,    1, 9, 32'h91,   1, 2, 0, 1));
    vecs.push_back(mk(1, 1, 9, 32'h92,   1, 3, 32'hA3,   3, 1,    1, 9, 32'h92,   1, 3, 1, 1));
    vecs.push_back(mk(1, 1, 9, 32'h93,   1, 4, 32'hA4,   3, 1,    1, 9, 32'h93,   0, 4, 1, 1)); // full
    vecs.push_back(mk(1, 1, 9, 32'h94,   1, 5, 32'hA5,   3, 1,    1, 9, 32'h94,   0, 4, 1, 1)); // not accepted
    vecs.push_back(mk(1, 0, 0, 32'h0,    0, 0, 32'h0,    3, 1,    1, 1, 32'hA1,   1, 3, 1, 0)); // drain in order
    vecs.push_back(mk(1, 0, 0, 32'h0,    0, 0, 32'h0,    3, 1,    1, 2, 32'hA2,   1, 2, 1, 0));
    vecs.push_back(mk(1, 0, 0, 32'h0,    1, 6, 32'hA6,   3, 1,    1, 3, 32'hA3,   1, 2, 0, 0)); // push+pop at 2
    vecs.push_back(mk(1, 0, 0, 32'h0,    0, 0, 32'h0,    3, 6,    1, 4, 32'hA4,   1, 1, 0, 1));
    vecs.push_back(mk(1, 0, 0, 32'h0,    0, 0, 32'h0,    3, 6,    1, 6, 32'hA6,   1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 32'h0,    0, 0, 32'h0,    0, 0,    0, 6, 32'hA6,   1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 32'h0,    1, 7, 32'hB0,   7, 0,    0, 6, 32'hA6,   1, 1, 1, 0)); // queue rd7
    vecs.push_back(mk(1, 1, 7, 32'hC0,   0, 0, 32'h0,    7, 0,    1, 7, 32'hC0,   1, 1, 0, 0)); // squash rd7
    vecs.push_back(mk(1, 0, 0, 32'h0,    0, 0, 32'h0,    7, 0,    0, 7, 32'hC0,   1, 0, 0, 0)); // squashed pop
    vecs.push_back(mk(1, 1, 8, 32'h80,   1, 8, 32'h88,   8, 0,    1, 8, 32'h80,   1, 1, 1, 0)); // same-cycle push stays live
    vecs.push_back(mk(1, 0, 0, 32'h0,    0, 0, 32'h0,    8, 0,    1, 8, 32'h88,   1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 32'h0,    1, 0, 32'hEE,   0, 0,    0, 8, 32'h88,   1, 0, 0, 0)); // b_rd x0
    vecs.push_back(mk(1, 0, 0, 32'h0,    0, 0, 32'h0,    0, 0,    0, 8, 32'h88,   1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 9, 32'h10,   1, 1, 32'h21,   5, 4,    1, 9, 32'h10,   1, 1, 0, 0)); // wrap round
    vecs.push_back(mk(1, 1, 9, 32'h11,   1, 2, 32'h22,   5, 4,    1, 9, 32'h11,   1, 2, 0, 0));
    vecs.push_back(mk(1, 1, 9, 32'h12,   1, 3, 32'h23,   5, 4,    1, 9, 32'h12,   1, 3, 0, 0));
    vecs.push_back(mk(1, 1, 9, 32'h13,   1, 4, 32'h24,   5, 4,    1, 9, 32'h13,   0, 4, 0, 1));
    vecs.push_back(mk(1, 0, 0, 32'h0,    1, 5, 32'h25,   5, 4,    1, 1, 32'h21,   1, 3, 0, 1)); // pop at full, no push
    vecs.push_back(mk(1, 0, 0, 32'h0,    1, 5, 32'h25,   5, 4,    1, 2, 32'h22,   1, 3, 1, 1));
    vecs.push_back(mk(1, 0, 0, 32'h0,    0, 0, 32'h0,    5, 4,    1, 3, 32'h23,   1, 2, 1, 1));
    vecs.push_back(mk(1, 0, 0, 32'h0,    0, 0, 32'h0,    5, 4,    1, 4, 32'h24,   1, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 32'h0,    0, 0, 32'h0,    5, 4,    1, 5, 32'h25,   1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 32'h0,    1, 3, 32'h33,   4, 0,    0, 5, 32'h25,   1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 32'h0,    1, 4, 32'h44,   4, 0,    1, 3, 32'h33,   1, 1, 1, 0));
    vecs.push_back(mk(0, 1, 9, 32'h99,   1, 6, 32'h66,   4, 0,    0, 0, 32'h0,    0, 0, 0, 0)); // reset mid-operation
    vecs.push_back(mk(1, 0, 0, 32'h0,    0, 0, 32'h0,    4, 0,    0, 0, 32'h0,    1, 0, 0, 0)); // nothing written

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst_n, vecs[i].a_valid, vecs[i].a_rd, vecs[i].a_data,
            vecs[i].b_valid, vecs[i].b_rd, vecs[i].b_data, vecs[i].rs1, vecs[i].rs2);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.we", i),       32'(we),       32'(vecs[i].exp_we));
      chk($sformatf("v%0d.wa", i),       32'(wa),       32'(vecs[i].exp_wa));
      chk($sformatf("v%0d.wd", i),       wd,            vecs[i].exp_wd);
      chk($sformatf("v%0d.b_ready", i),  32'(b_ready),  32'(vecs[i].exp_b_ready));
      chk($sformatf("v%0d.lq_count", i), 32'(lq_count), 32'(vecs[i].exp_cnt));
      chk($sformatf("v%0d.rs1_pend", i), 32'(rs1_pend), 32'(vecs[i].exp_p1));
      chk($sformatf("v%0d.rs2_pend", i), 32'(rs2_pend), 32'(vecs[i].exp_p2));
    end

    // Starvation: eight back-to-back ALU writes while the B side keeps offering; only four fit.
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      drive(1, 1, 9, 32'(c), 1, 5'(10 + c), 32'h100 + 32'(c), 0, 0);
      @(posedge clk);
      #1;
    end
    chk("starve.lq_count", 32'(lq_count), 32'd4);
    chk("starve.b_ready",  32'(b_ready),  32'd0);
    chk("starve.wa",       32'(wa),       32'd9);
    chk("starve.wd",       wd,            32'd7);

    // First idle cycle at full: b_ready stays low across the pop, so the offered entry is refused.
    @(negedge clk);
    drive(1, 0, 0, 0, 1, 20, 32'h200, 0, 0);
    chk("popfull.b_ready_pre", 32'(b_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("popfull.we",       32'(we),       32'd1);
    chk("popfull.wa",       32'(wa),       32'd10);
    chk("popfull.wd",       wd,            32'h100);
    chk("popfull.lq_count", 32'(lq_count), 32'd3);

    // Drain the rest within a bounded window and check order.
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    nw = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (we) begin
        chk($sformatf("drain%0d.wa", nw), 32'(wa), 32'(11 + nw));
        chk($sformatf("drain%0d.wd", nw), wd,      32'h101 + 32'(nw));
        nw++;
      end
    end
    chk("drain.writes",   32'(nw),       32'd3);
    chk("drain.lq_count", 32'(lq_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
